// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C commands, issues them one at a time over the
// master's enable/ready handshake and returns in-order responses through a FIFO.
module i2c_cmd_sequencer #(
    parameter int CMD_DEPTH     = 4,
    parameter int RSP_DEPTH     = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       i2c_clk_100k,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [6:0]                 cmd_addr,
    input  logic [7:0]                 cmd_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_err,
    output logic [6:0]                 m_addr,
    output logic [7:0]                 m_data_in,
    output logic                       m_rw,
    output logic                       m_enable,
    input  logic [7:0]                 m_data_out,
    input  logic                       m_ready,
    output logic                       busy,
    output logic [$clog2(CMD_DEPTH):0] cmd_level
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   cmd_mem_q [CMD_DEPTH];
    logic [15:0]   cmd_mem_d [CMD_DEPTH];
    logic [8:0]    rsp_mem_q [RSP_DEPTH];
    logic [8:0]    rsp_mem_d [RSP_DEPTH];
    logic [CAW:0]  cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d, cmd_cnt;
    logic [RAW:0]  rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d, rsp_cnt;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [6:0]    m_addr_q, m_addr_d;
    logic [7:0]    m_data_in_q, m_data_in_d;
    logic          m_rw_q, m_rw_d, m_enable_q, m_enable_d;
    logic          cmd_push, cmd_pop, rsp_push, rsp_pop;
    logic [8:0]    rsp_new;
    logic [15:0]   cmd_head;

    always_comb begin
        cmd_cnt             = cmd_wr_q - cmd_rd_q;
        rsp_cnt             = rsp_wr_q - rsp_rd_q;
        // Depths are powers of two, so the count MSB alone means full
        cmd_ready           = !cmd_cnt[CAW];
        rsp_valid           = rsp_cnt != '0;
        cmd_push            = cmd_valid && cmd_ready;
        rsp_pop             = rsp_valid && rsp_ready;
        cmd_head            = cmd_mem_q[cmd_rd_q[CAW-1:0]];
        {rsp_err, rsp_data} = rsp_mem_q[rsp_rd_q[RAW-1:0]];
        cmd_level           = cmd_cnt;
        busy                = state_q != IDLE;
        m_addr              = m_addr_q;
        m_data_in           = m_data_in_q;
        m_rw                = m_rw_q;
        m_enable            = m_enable_q;
        state_d             = state_q;
        tmo_d               = tmo_q;
        m_addr_d            = m_addr_q;
        m_data_in_d         = m_data_in_q;
        m_rw_d              = m_rw_q;
        m_enable_d          = m_enable_q;
        cmd_pop             = 1'b0;
        rsp_push            = 1'b0;
        rsp_new             = '0;
        case (state_q)
            IDLE: begin
                // Nothing is in flight here, so a free response slot is all that is needed
                if (cmd_cnt != '0 && m_ready && !rsp_cnt[RAW]) begin
                    cmd_pop                           = 1'b1;
                    {m_rw_d, m_addr_d, m_data_in_d}   = cmd_head;
                    m_enable_d                        = 1'b1;
                    tmo_d                             = '0;
                    state_d                           = LAUNCH;
                end
            end
            LAUNCH: begin
                tmo_d = tmo_q + TW'(1);
                if (!m_ready) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    m_enable_d = 1'b0;
                    rsp_push   = 1'b1;
                    rsp_new    = {1'b1, 8'h00};
                    state_d    = IDLE;
                end
            end
            WAIT_DONE: begin
                if (m_ready) begin
                    m_enable_d = 1'b0;
                    rsp_push   = 1'b1;
                    rsp_new    = {1'b0, m_rw_q ? m_data_out : 8'h00};
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_wr_d  = cmd_wr_q + {{CAW{1'b0}}, cmd_push};
        cmd_rd_d  = cmd_rd_q + {{CAW{1'b0}}, cmd_pop};
        rsp_wr_d  = rsp_wr_q + {{RAW{1'b0}}, rsp_push};
        rsp_rd_d  = rsp_rd_q + {{RAW{1'b0}}, rsp_pop};
        cmd_mem_d = cmd_mem_q;
        if (cmd_push) cmd_mem_d[cmd_wr_q[CAW-1:0]] = {cmd_rw, cmd_addr, cmd_data};
        rsp_mem_d = rsp_mem_q;
        if (rsp_push) rsp_mem_d[rsp_wr_q[RAW-1:0]] = rsp_new;
    end

    always_ff @(posedge i2c_clk_100k or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmd_mem_q   <= '{default: '0};
            rsp_mem_q   <= '{default: '0};
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            rsp_wr_q    <= '0;
            rsp_rd_q    <= '0;
            tmo_q       <= '0;
            m_addr_q    <= '0;
            m_data_in_q <= '0;
            m_rw_q      <= 1'b0;
            m_enable_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_mem_q   <= cmd_mem_d;
            rsp_mem_q   <= rsp_mem_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rd_q    <= rsp_rd_d;
            tmo_q       <= tmo_d;
            m_addr_q    <= m_addr_d;
            m_data_in_q <= m_data_in_d;
            m_rw_q      <= m_rw_d;
            m_enable_q  <= m_enable_d;
        end
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// tb_i2c_cmd_sequencer: randomized host and master models around the sequencer,
// checked against a transaction-level scoreboard of queued commands and responses.
module tb_i2c_cmd_sequencer;
    localparam int CD = 4;
    localparam int RD = 4;
    localparam int TO = 16;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid, rsp_ready, rsp_err;
    logic [7:0] rsp_data;
    logic [6:0] m_addr;
    logic [7:0] m_data_in, m_data_out;
    logic       m_rw, m_enable, m_ready, busy;
    logic [2:0] cmd_level;

    int checks = 0;
    int errors = 0;

    cmd_t       cmd_q[$];
    cmd_t       host_q[$];
    cmd_t       cur;
    logic [8:0] exp_q[$];
    int         lvl_m, rsp_m, en_cnt, exp_len, mphase, mdel, mlow, n_pop;
    int         pop_mode, tmo_mode, fix_len, fix_data;
    bit         en_prev, ready_prev, act, pend_push, pend_pop, rand_push;
    logic [7:0] mdata;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.CMD_DEPTH(CD), .RSP_DEPTH(RD), .START_TIMEOUT(TO)) dut (
        .i2c_clk_100k(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_addr(m_addr), .m_data_in(m_data_in), .m_rw(m_rw), .m_enable(m_enable),
        .m_data_out(m_data_out), .m_ready(m_ready),
        .busy(busy), .cmd_level(cmd_level)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic rw, input logic [6:0] addr, input logic [7:0] data);
        cmd_t c;
        c.rw   = rw;
        c.addr = addr;
        c.data = data;
        return c;
    endfunction

    task automatic clear_model();
        cmd_q.delete();
        exp_q.delete();
        host_q.delete();
        lvl_m      = 0;
        rsp_m      = 0;
        act        = 0;
        en_prev    = 0;
        mphase     = 0;
        pend_push  = 0;
        pend_pop   = 0;
        cmd_valid  = 1'b0;
        cmd_rw     = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        m_ready    = 1'b1;
        m_data_out = '0;
        ready_prev = 1;
    endtask

    // One clock cycle: observe at the falling edge, update the scoreboard, then drive inputs.
    task automatic step();
        int   lvl_old, rsp_old, d, len;
        bit   rise, fall, exp_rise, tmo;
        cmd_t c;
        @(negedge clk);
        lvl_old  = lvl_m;
        rsp_old  = rsp_m;
        rise     = m_enable && !en_prev;
        fall     = !m_enable && en_prev;
        exp_rise = !en_prev && lvl_old > 0 && ready_prev && rsp_old < RD;
        check("launch", rise, exp_rise);
        lvl_m = lvl_m + int'(pend_push) - int'(rise);
        rsp_m = rsp_m - int'(pend_pop) + int'(fall);
        if (fall) begin
            check("en_len", en_cnt, exp_len);
            act    = 0;
            mphase = 0;
        end
        if (rise) begin
            if (cmd_q.size() > 0) cur = cmd_q.pop_front();
            act    = 1;
            en_cnt = 0;
            tmo    = tmo_mode == 1 || (tmo_mode == 2 && $urandom_range(7) == 0);
            if (tmo) begin
                mphase  = 4;
                exp_len = TO;
                exp_q.push_back(9'h100);
            end else begin
                d       = $urandom_range(3);
                len     = fix_len > 0 ? fix_len : $urandom_range(6, 1);
                mdata   = fix_data >= 0 ? 8'(fix_data) : 8'($urandom);
                mdel    = d;
                mlow    = len;
                exp_len = 1 + d + len;
                mphase  = 1;
                exp_q.push_back({1'b0, cur.rw ? mdata : 8'h00});
            end
        end
        if (m_enable) en_cnt++;
        if (act) begin
            check("m_addr", m_addr, cur.addr);
            check("m_data_in", m_data_in, cur.data);
            check("m_rw", m_rw, cur.rw);
        end
        check("busy", busy, act);
        check("cmd_level", cmd_level, lvl_m);
        check("cmd_ready", cmd_ready, lvl_m < CD);
        check("rsp_valid", rsp_valid, rsp_m > 0);
        if (mphase != 3) m_data_out = 8'($urandom);
        case (mphase)
            1: if (mdel == 0) begin
                m_ready = 1'b0;
                mphase  = 2;
            end else mdel--;
            2: begin
                mlow--;
                if (mlow == 0) begin
                    m_ready    = 1'b1;
                    m_data_out = mdata;
                    mphase     = 3;
                end
            end
            default: ;
        endcase
        ready_prev = m_ready;
        en_prev    = m_enable;
        pend_push  = 0;
        cmd_valid  = 1'b0;
        if (host_q.size() > 0 || (rand_push && $urandom_range(1) == 1)) begin
            if (host_q.size() > 0) c = host_q[0];
            else c = mk(1'($urandom), 7'($urandom), 8'($urandom));
            cmd_valid = 1'b1;
            cmd_rw    = c.rw;
            cmd_addr  = c.addr;
            cmd_data  = c.data;
            pend_push = lvl_m < CD;
            if (pend_push) begin
                cmd_q.push_back(c);
                if (host_q.size() > 0) host_q.delete(0);
            end
        end
        rsp_ready = pop_mode == 1 || (pop_mode == 2 && $urandom_range(1) == 1);
        pend_pop  = rsp_ready && rsp_m > 0;
        if (pend_pop && exp_q.size() > 0) begin
            check("rsp", {rsp_err, rsp_data}, exp_q.pop_front());
            n_pop++;
        end
    endtask

    initial begin
        pop_mode  = 0;
        tmo_mode  = 0;
        fix_len   = 0;
        fix_data  = -1;
        rand_push = 0;
        n_pop     = 0;
        clear_model();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_data_in", m_data_in, 0);
        check("rst_m_rw", m_rw, 0);
        check("rst_m_enable", m_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_level", cmd_level, 0);
        rst = 1'b1;

        // Single write with a long master transfer
        fix_len  = 20;
        pop_mode = 1;
        n_pop    = 0;
        host_q.push_back(mk(1'b0, 7'h2A, 8'hAA));
        repeat (40) step();
        check("write_done", n_pop, 1);

        // Single read returning 0x5C
        fix_len  = 3;
        fix_data = 8'h5C;
        n_pop    = 0;
        host_q.push_back(mk(1'b1, 7'h2A, 8'h00));
        repeat (20) step();
        check("read_done", n_pop, 1);
        fix_data = -1;

        // Back-to-back with responses held: response FIFO fills, then launches stall
        pop_mode = 0;
        fix_len  = 2;
        host_q.push_back(mk(1'b1, 7'h11, 8'h11));
        host_q.push_back(mk(1'b0, 7'h22, 8'h22));
        host_q.push_back(mk(1'b1, 7'h33, 8'h33));
        host_q.push_back(mk(1'b0, 7'h44, 8'h44));
        for (int i = 0; i < 4; i++) host_q.push_back(mk(1'($urandom), 7'($urandom), 8'($urandom)));
        repeat (60) step();
        check("b2b_level", cmd_level, 4);
        check("b2b_busy", busy, 0);
        check("b2b_rsp_valid", rsp_valid, 1);

        // Full command FIFO: push refused while a pop happens in the same cycle
        host_q.push_back(mk(1'b0, 7'h55, 8'h66));
        pop_mode = 1;
        step();
        pop_mode = 0;
        step();
        step();
        check("full_refuse", cmd_level, 3);
        pop_mode = 2;
        repeat (150) step();
        pop_mode = 1;
        repeat (20) step();
        check("b2b_drain", exp_q.size(), 0);

        // Start timeout, then a normal launch afterwards
        fix_len  = 0;
        tmo_mode = 1;
        host_q.push_back(mk(1'b1, 7'h10, 8'h00));
        repeat (30) step();
        tmo_mode = 0;
        host_q.push_back(mk(1'b1, 7'h12, 8'h00));
        repeat (20) step();
        check("tmo_drain", exp_q.size(), 0);

        // Reset during WAIT_DONE with a second command queued
        fix_len = 20;
        host_q.push_back(mk(1'b1, 7'h3C, 8'h00));
        host_q.push_back(mk(1'b0, 7'h3D, 8'h77));
        for (int i = 0; i < 40 && !(mphase == 2 && lvl_m > 0); i++) step();
        check("reach_wait", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_enable", m_enable, 0);
        check("rst_mid_level", cmd_level, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rsp", rsp_valid, 0);
        clear_model();
        @(negedge clk);
        rst = 1'b1;
        repeat (20) step();

        // Randomized traffic, then drain
        fix_len   = 0;
        rand_push = 1;
        pop_mode  = 2;
        tmo_mode  = 2;
        repeat (2000) step();
        rand_push = 0;
        pop_mode  = 1;
        tmo_mode  = 0;
        repeat (200) step();
        check("final_drain", exp_q.size(), 0);
        check("final_level", cmd_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_sequencer.md
# i2c_cmd_sequencer

Command sequencer that sits directly upstream of `i2c_master_controller` and drives its `addr`/`data_in`/`rw`/`enable` inputs.
- Accepts queued I2C transactions (read/write, 7-bit address, write byte) from a host over a valid/ready port.
- Issues them to the master one at a time, using the master's `enable`/`ready` handshake.
- Returns one in-order response per command (read byte or zero, plus error flag) through a response FIFO.
- Removes the need for host logic to poll `ready` and time `enable` by hand.

## Interface
Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, at least 2.
- RSP_DEPTH, 4, response FIFO entries; power of two, at least 2.
- START_TIMEOUT, 16, cycles to wait for the master to drop `ready` after `enable` rises; at least 2.

Ports:
- i2c_clk_100k  in  1  single clock, rising edge; the same clock that drives the master.
- rst  in  1  asynchronous, active-low reset; all state is cleared while low.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command FIFO not full.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  7  target slave address.
- cmd_data  in  8  write byte; ignored for reads.
- rsp_valid  out  1  response FIFO not empty.
- rsp_ready  in  1  host pops the head response.
- rsp_data  out  8  read byte; 0x00 for writes and for errors.
- rsp_err  out  1  1 = start timeout.
- m_addr  out  7  to master `addr`.
- m_data_in  out  8  to master `data_in`.
- m_rw  out  1  to master `rw`.
- m_enable  out  1  to master `enable`.
- m_data_out  in  8  from master `data_out`.
- m_ready  in  1  from master `ready`; high = idle or done, low = busy.
- busy  out  1  FSM not in IDLE.
- cmd_level  out  $clog2(CMD_DEPTH)+1  current command FIFO occupancy.

## Operation
- Command FIFO: entries are {rw, addr, data}.
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full. When full, a push is refused even if a pop happens in the same cycle.
- Response FIFO: entries are {err, data}.
  - rsp_valid = !empty; rsp_data/rsp_err always show the head entry.
  - Pop when rsp_valid && rsp_ready.
  - Push and pop in the same cycle is allowed when not empty.
- Every accepted command produces exactly one response, in command order.
- FSM states:
  - IDLE: move to LAUNCH when the command FIFO is not empty, m_ready=1, and the response FIFO has at least one free slot counting in-flight commands (at most one). On that edge, pop the command, register m_addr/m_data_in/m_rw, set m_enable=1, clear the timeout counter.
  - LAUNCH: m_enable held at 1, counter increments each cycle.
    - m_ready=0 → WAIT_DONE.
    - Otherwise, counter == START_TIMEOUT-1 → m_enable=0, push {err=1, data=0x00}, go to IDLE.
  - WAIT_DONE: m_enable held at 1. On m_ready=1, on the same edge: m_enable=0, push {err=0, data = m_rw ? m_data_out : 0x00}, go to IDLE.
- m_addr, m_data_in and m_rw stay stable from LAUNCH entry until the FSM re-enters IDLE. They keep their last value in IDLE.
- No timeout in WAIT_DONE; the master bounds the transfer length.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0x00, rsp_err=0, m_addr=0, m_data_in=0, m_rw=0, m_enable=0, busy=0, cmd_level=0. Both FIFO pointers are zero.
- Reset asserted mid-transaction: m_enable drops immediately (asynchronously). The queued and in-flight commands are discarded and produce no response.
- Command accepted at edge N into an empty FIFO while the FSM is idle and m_ready=1:
  - cmd_level=1 after edge N.
  - FIFO pop and m_enable=1 at edge N+1.
- Response visible one cycle after the completing edge:
  - rsp_valid=1 after the edge where m_ready was sampled high in WAIT_DONE.
  - Data is m_data_out as sampled at that edge.
- Minimum gap between transactions: m_enable is low for at least 1 cycle before the next launch.
- Timeout: m_enable is high for exactly START_TIMEOUT cycles if m_ready never falls.
- Response FIFO full: IDLE stalls. No launch happens and the command stays queued until the host pops a response.

## Test plan
- Write: push {rw=0, addr=0x2A, data=0xAA}; master model drops ready for 20 cycles → m_addr=0x2A, m_data_in=0xAA, m_rw=0; m_enable high for 21+ cycles then low; response {err=0, data=0x00}.
- Read: push {rw=1, addr=0x2A}; model returns 0x5C → rsp_data=0x5C, rsp_err=0, rsp_valid=1 one cycle after ready returns high.
- Back-to-back: push 4 commands (read 0x11, write 0x22, read 0x33, write 0x44) while holding rsp_ready=0 → cmd_ready=0 with 4 queued; after 4 completions the 5th launch stalls; responses pop in order.
- Timeout: model holds m_ready=1 permanently → m_enable high for exactly 16 cycles; response {err=1, data=0x00}; the next command launches normally.
- Reset mid-read: assert rst low during WAIT_DONE → m_enable=0 and cmd_level=0 immediately; no response emitted after rst is released.
- Full-FIFO edge case: with 4 queued, push and pop in the same cycle → push refused, cmd_level goes 4→3.
